// File: rtl/mic_ram_pkg.sv
// Shared types and defaults for the microphone-to-RAM capture path.
//   state_t       : capture FSM states
//   *_DEF         : default geometry for mic_ram_writer
//   BYTE_EN_ALL   : full-word byte enable for the RAM s2 port
package mic_ram_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned OVR_W_DEF    = 16;

  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

endpackage

// File: rtl/mic_sample_packer.sv
// Pairs consecutive accepted samples into one word {second, first}.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   accept        : s_data is a sample to take this cycle
//   flush         : drop any unpaired sample held in the slot
//   s_data        : sample value
//   word_valid_c  : combinational, a pair completes this cycle
//   word_c        : combinational, {s_data, held first sample}
module mic_sample_packer #(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic                  flush,
  input  logic [SAMPLE_W-1:0]   s_data,
  output logic                  word_valid_c,
  output logic [2*SAMPLE_W-1:0] word_c
);

  logic                slot_full;
  logic [SAMPLE_W-1:0] slot_data;

  assign word_valid_c = accept && slot_full;
  assign word_c       = {s_data, slot_data};

  // Low half-word holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full <= 1'b0;
      slot_data <= '0;
    end else if (flush) begin
      slot_full <= 1'b0;
    end else if (accept) begin
      if (slot_full) begin
        slot_full <= 1'b0;
      end else begin
        slot_full <= 1'b1;
        slot_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/mic_ram_writer.sv
// Streams microphone samples, packed two per word, into a dual-port RAM
// used as two ping-pong halves; software holds a half until it releases it.
// Optional header word per half: define MIC_RAM_WRITER_TAG_EN.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : capture enable (level)
//   s_valid, s_data     : sample strobe and value
//   buf_release         : pulse, software drained half release_id
//   release_id          : half being released
//   ram_*               : RAM s2 port (address, chipselect, clken, write,
//                         writedata, byteenable)
//   half_done, half_id  : one-cycle pulse and id of a completed half
//   half_busy           : per-half "held by software" flags
//   overrun_cnt         : saturating count of dropped samples
module mic_ram_writer
  import mic_ram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned OVR_W    = OVR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  buf_release,
  input  logic                  release_id,
  output logic [ADDR_W-1:0]     ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_clken,
  output logic                  ram_write,
  output logic [2*SAMPLE_W-1:0] ram_writedata,
  output logic [3:0]            ram_byteenable,
  output logic                  half_done,
  output logic                  half_id,
  output logic [1:0]            half_busy,
  output logic [OVR_W-1:0]      overrun_cnt
);

  localparam int unsigned WORD_W = 2 * SAMPLE_W;
  localparam int unsigned OFF_W  = ADDR_W - 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic                last_pending;   // last word of a half was written last edge
  logic                accept_c;
  logic                flush_c;
  logic                pk_valid_c;
  logic [WORD_W-1:0]   pk_word_c;
  logic [1:0]          busy_nxt_c;
  logic                tgt_half_c;
  logic                hdr_now_c;
  logic                wr_c;
  logic [WORD_W-1:0]   wr_data_c;

`ifdef MIC_RAM_WRITER_TAG_EN
  logic                hdr_pending;
  logic [SAMPLE_W-1:0] frame_seq;
  logic [SAMPLE_W-1:0] hdr_seq_c;
`endif

  assign ram_clken      = 1'b1;
  assign ram_byteenable = BYTE_EN_ALL;

  // Half the pointer currently targets (already wrapped after a last word)
  assign tgt_half_c = ptr[ADDR_W-1];

  mic_sample_packer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .accept       (accept_c),
    .flush        (flush_c),
    .s_data       (s_data),
    .word_valid_c (pk_valid_c),
    .word_c       (pk_word_c)
  );

  // Busy flags: release clears, completion sets; set wins on the same half
  always_comb begin
    busy_nxt_c = half_busy;
    if (buf_release) busy_nxt_c[release_id] = 1'b0;
    if (last_pending) busy_nxt_c[ram_address[ADDR_W-1]] = 1'b1;
  end

  // Next state and sample acceptance
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = half_busy[tgt_half_c] ? WAIT_FREE : FILL;
      end
      FILL: begin
        accept_c = enable && s_valid;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (last_pending && busy_nxt_c[tgt_half_c]) begin
          state_nxt = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (!half_busy[tgt_half_c]) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
    flush_c = (state_nxt != FILL);
  end

  // Write source: header word (optional) or a completed sample pair
  always_comb begin
`ifdef MIC_RAM_WRITER_TAG_EN
    // On a wrap that stays in FILL the header carries the incremented sequence
    hdr_seq_c = last_pending ? frame_seq + SAMPLE_W'(1) : frame_seq;
    hdr_now_c = (state == FILL) && enable &&
                (hdr_pending || (last_pending && state_nxt == FILL));
    wr_data_c = hdr_now_c ? {hdr_seq_c, SAMPLE_W'(overrun_cnt)} : pk_word_c;
`else
    hdr_now_c = 1'b0;
    wr_data_c = pk_word_c;
`endif
    wr_c = pk_valid_c || hdr_now_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // RAM port, pointer, completion and overrun bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= '0;
      last_pending   <= 1'b0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      half_done      <= 1'b0;
      half_id        <= 1'b0;
      half_busy      <= 2'b00;
      overrun_cnt    <= '0;
    end else begin
      ram_write      <= wr_c;
      ram_chipselect <= wr_c;
      last_pending   <= 1'b0;
      if (wr_c) begin
        ram_address   <= ptr;
        ram_writedata <= wr_data_c;
        last_pending  <= &ptr[OFF_W-1:0];
      end
      // Disable abandons the partial half: restart at its first word
      if (!enable)   ptr <= {ptr[ADDR_W-1], {OFF_W{1'b0}}};
      else if (wr_c) ptr <= ptr + ADDR_W'(1);

      half_done <= last_pending;
      if (last_pending) half_id <= ram_address[ADDR_W-1];
      half_busy <= busy_nxt_c;

      if ((state == WAIT_FREE) && s_valid && !(&overrun_cnt))
        overrun_cnt <= overrun_cnt + OVR_W'(1);
    end
  end

`ifdef MIC_RAM_WRITER_TAG_EN
  // Header request on FILL entry and per-half frame sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_pending <= 1'b0;
      frame_seq   <= '0;
    end else begin
      if (state_nxt != FILL)  hdr_pending <= 1'b0;
      else if (state != FILL) hdr_pending <= 1'b1;
      else if (hdr_now_c)     hdr_pending <= 1'b0;
      if (last_pending) frame_seq <= frame_seq + SAMPLE_W'(1);
    end
  end
`endif

endmodule
